// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field handshake plus instruction-memory write bus for instr_encoder_loader
// master drives control, fields and mem_ready; slave (the loader) drives in_ready, write bus and status
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [15:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  err_cnt;
  modport master (
    output start, base_addr, len, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );
  modport slave (
    input  start, base_addr, len, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_cnt
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded fields into 16-bit ISA words and writes len of them from base_addr
// ports: clk, rst_n (async active-low), bus (instr_encoder_loader_if.slave: start/base_addr/len control,
//   in_valid/in_ready field handshake with in_op/in_rd/in_rs1/in_rs2/in_imm, mem_we/mem_addr/mem_wdata/mem_ready
//   write bus, busy/done/err/err_cnt status)
// macro IMM_SAT_EN: out-of-range immediates saturate to the field limit instead of encoding as zero
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  instr_encoder_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, mem_addr_r;
  logic [LEN_W-1:0]  rem, err_cnt_r;
  logic [15:0]       word, mem_wdata_r;
  logic [7:0]        f8;
  logic [3:0]        f4;
  logic              err_r, is_j, is_r, is_b, ok8, ok4, illegal, go, hs, wr_ok;
  always_comb begin
    is_j = bus.in_op == 4'b0000;
    is_r = bus.in_op[3:2] == 2'b10;
    is_b = !bus.in_op[3] && bus.in_op[1];
    ok8  = &bus.in_imm[15:7] || ~|bus.in_imm[15:7];
    ok4  = &bus.in_imm[15:3] || ~|bus.in_imm[15:3];
`ifdef IMM_SAT_EN
    f8   = ok8 ? bus.in_imm[7:0] : (bus.in_imm[15] ? 8'h80 : 8'h7f);
    f4   = ok4 ? bus.in_imm[3:0] : (bus.in_imm[15] ? 4'h8 : 4'h7);
`else
    f8   = ok8 ? bus.in_imm[7:0] : 8'h00;
    f4   = ok4 ? bus.in_imm[3:0] : 4'h0;
`endif
    word = is_j ? {f8, bus.in_rd, bus.in_op} :
           is_r ? {bus.in_rs2, bus.in_rs1, bus.in_rd, bus.in_op} :
           is_b ? {bus.in_rs2, bus.in_rs1, f4, bus.in_op} :
                  {f4, bus.in_rs1, bus.in_rd, bus.in_op};
    illegal = is_j ? !ok8 : (!is_r && !ok4);
  end
  always_comb begin
    go    = bus.start && (state == IDLE || state == DONE);
    hs    = state == ACCEPT && bus.in_valid;
    wr_ok = state == WRITE && bus.mem_ready;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = bus.len == '0 ? DONE : ACCEPT;
      ACCEPT:     if (bus.in_valid) state_nx = WRITE;
      WRITE:      if (bus.mem_ready) state_nx = rem == LEN_W'(1) ? DONE : ACCEPT;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr        <= '0;
      rem         <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      err_r       <= 1'b0;
      err_cnt_r   <= '0;
    end else if (go) begin
      addr      <= bus.base_addr;
      rem       <= bus.len;
      err_r     <= 1'b0;
      err_cnt_r <= '0;
    end else if (hs) begin
      mem_addr_r  <= addr;
      mem_wdata_r <= word;
      if (illegal) begin
        err_r     <= 1'b1;
        err_cnt_r <= err_cnt_r + LEN_W'(err_cnt_r != '1);
      end
    end else if (wr_ok) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
  assign bus.in_ready  = state == ACCEPT;
  assign bus.mem_we    = state == WRITE;
  assign bus.busy      = state == ACCEPT || state == WRITE;
  assign bus.done      = state == DONE;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.err       = err_r;
  assign bus.err_cnt   = err_cnt_r;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized self-checking bench for instr_encoder_loader against an arithmetic encoding model
module tb_instr_encoder_loader;
  localparam int AW = 8;
  localparam int LW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_encoder_loader_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();
  instr_encoder_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_pass = 0;
  int n_total = 0;
  logic [3:0]  op_a [16];
  logic [3:0]  rd_a [16];
  logic [3:0]  rs1_a [16];
  logic [3:0]  rs2_a [16];
  logic [15:0] imm_a [16];
  logic [7:0]  wa [$];
  logic [15:0] wd [$];
  int stall_cycles = 0;
  int stall_bad = 0;
  bit in_stall = 0;
  logic [7:0]  st_a;
  logic [15:0] st_d;
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_ready) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (bus.mem_we && !bus.mem_ready) begin
      if (!in_stall) begin
        st_a = bus.mem_addr;
        st_d = bus.mem_wdata;
        in_stall = 1;
      end else if (bus.mem_addr !== st_a || bus.mem_wdata !== st_d) stall_bad++;
      if (bus.in_ready !== 1'b0) stall_bad++;
      stall_cycles++;
    end else in_stall = 0;
  end
  function automatic logic [15:0] model_word(input logic [3:0] op, rd, rs1, rs2, input logic [15:0] imm, output bit bad);
    int v, lo, hi, f, kind, w;
    v = $signed(imm);
    if (op == 4'd0) kind = 0;
    else if (op inside {4'd8, 4'd9, 4'd10, 4'd11}) kind = 3;
    else if (op inside {4'd2, 4'd3, 4'd6, 4'd7}) kind = 2;
    else kind = 1;
    lo = kind == 0 ? -128 : -8;
    hi = kind == 0 ? 127 : 7;
    bad = kind != 3 && (v < lo || v > hi);
`ifdef IMM_SAT_EN
    f = !bad ? v : (v < lo ? lo : hi);
`else
    f = !bad ? v : 0;
`endif
    case (kind)
      0:       w = (f & 255) * 256 + int'(rd) * 16 + int'(op);
      1:       w = (f & 15) * 4096 + int'(rs1) * 256 + int'(rd) * 16 + int'(op);
      2:       w = int'(rs2) * 4096 + int'(rs1) * 256 + (f & 15) * 16 + int'(op);
      default: w = int'(rs2) * 4096 + int'(rs1) * 256 + int'(rd) * 16 + int'(op);
    endcase
    return 16'(w);
  endfunction
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic set_instr(input int i, input logic [3:0] op, rd, rs1, rs2, input logic [15:0] imm);
    op_a[i] = op; rd_a[i] = rd; rs1_a[i] = rs1; rs2_a[i] = rs2; imm_a[i] = imm;
  endtask
  task automatic pulse_start(input logic [7:0] base, input int n);
    bus.base_addr = base;
    bus.len = 8'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic feed(input int n, input int stall);
    int i = 0;
    int cyc = 0;
    int left = stall;
    bit hs;
    while ((i < n || !bus.done) && cyc < 400) begin
      bus.mem_ready = left == 0;
      bus.in_valid = i < n;
      if (i < n) begin
        bus.in_op = op_a[i]; bus.in_rd = rd_a[i]; bus.in_rs1 = rs1_a[i];
        bus.in_rs2 = rs2_a[i]; bus.in_imm = imm_a[i];
      end
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (bus.mem_we && left > 0) left--;
      tick();
      if (hs) i++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    n_total++;
    if (cyc >= 400) $display("FAIL load_timeout: wrote %0d of %0d words within 400 cycles, done=%0b", i, n, bus.done);
    else n_pass++;
  endtask
  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_total++; if ({bus.in_ready, bus.mem_we, bus.busy, bus.done} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {bus.in_ready, bus.mem_we, bus.busy, bus.done}); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'h0000) $display("FAIL reset_wdata: got %h want 0000", bus.mem_wdata); else n_pass++;
    n_total++; if ({bus.err, bus.err_cnt} !== 9'h0) $display("FAIL reset_err: got %b/%0d want 0/0", bus.err, bus.err_cnt); else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask
  task automatic test_jal;
    wa.delete(); wd.delete();
    pulse_start(8'h10, 1);
    bus.in_op = 4'h0; bus.in_rd = 4'h3; bus.in_rs1 = 4'h0; bus.in_rs2 = 4'h0; bus.in_imm = 16'hFFFE;
    bus.in_valid = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) $display("FAIL jal_accept: in_ready=%b busy=%b want 1 1", bus.in_ready, bus.busy); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (bus.mem_we !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL jal_latency: mem_we=%b in_ready=%b want 1 0", bus.mem_we, bus.in_ready); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h10) $display("FAIL jal_addr: got %h want 10", bus.mem_addr); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'hFE30) $display("FAIL jal_wdata: got %h want FE30", bus.mem_wdata); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({bus.done, bus.busy, bus.mem_we, bus.err} !== 4'b1000) $display("FAIL jal_done: done/busy/we/err=%b want 1000", {bus.done, bus.busy, bus.mem_we, bus.err}); else n_pass++;
    n_total++; if (bus.mem_wdata !== 16'hFE30 || bus.mem_addr !== 8'h10) $display("FAIL jal_hold: got %h@%h want FE30@10", bus.mem_wdata, bus.mem_addr); else n_pass++;
  endtask
  task automatic test_pair;
    wa.delete(); wd.delete();
    set_instr(0, 4'hC, 4'h1, 4'h2, 4'h0, 16'd7);
    set_instr(1, 4'h6, 4'h0, 4'h5, 4'h6, 16'hFFFF);
    pulse_start(8'h40, 2);
    feed(2, 0);
    n_total++; if (wa.size() !== 2) $display("FAIL pair_count: got %0d want 2", wa.size()); else n_pass++;
    n_total++; if (wd[0] !== 16'h721C || wa[0] !== 8'h40) $display("FAIL pair_w0: got %h@%h want 721C@40", wd[0], wa[0]); else n_pass++;
    n_total++; if (wd[1] !== 16'h65F6 || wa[1] !== 8'h41) $display("FAIL pair_w1: got %h@%h want 65F6@41", wd[1], wa[1]); else n_pass++;
  endtask
  task automatic test_illegal;
    logic [15:0] e0, e1;
    bit b0, b1;
    wa.delete(); wd.delete();
    set_instr(0, 4'hC, 4'h1, 4'h2, 4'h0, 16'd8);
    set_instr(1, 4'h0, 4'h5, 4'h0, 4'h0, 16'd200);
    e0 = model_word(op_a[0], rd_a[0], rs1_a[0], rs2_a[0], imm_a[0], b0);
    e1 = model_word(op_a[1], rd_a[1], rs1_a[1], rs2_a[1], imm_a[1], b1);
    pulse_start(8'h20, 2);
    feed(2, 0);
    n_total++; if (wd[0] !== e0) $display("FAIL illegal_addi: got %h want %h", wd[0], e0); else n_pass++;
    n_total++; if (wd[1] !== e1) $display("FAIL illegal_jal: got %h want %h", wd[1], e1); else n_pass++;
    n_total++; if (bus.err !== 1'b1 || bus.err_cnt !== 8'(int'(b0) + int'(b1))) $display("FAIL illegal_err: got %b/%0d want 1/%0d", bus.err, bus.err_cnt, int'(b0) + int'(b1)); else n_pass++;
    set_instr(0, 4'h9, 4'h2, 4'h3, 4'h4, 16'h8000);
    pulse_start(8'h22, 1);
    feed(1, 0);
    n_total++; if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) $display("FAIL err_clear: got %b/%0d want 0/0", bus.err, bus.err_cnt); else n_pass++;
    n_total++; if (wd[2] !== 16'h4329) $display("FAIL rtype_ignore_imm: got %h want 4329", wd[2]); else n_pass++;
  endtask
  task automatic test_stall_wrap;
    logic [15:0] e0, e1;
    bit b;
    wa.delete(); wd.delete();
    stall_cycles = 0; stall_bad = 0;
    set_instr(0, 4'h3, 4'h0, 4'hA, 4'hB, 16'hFFF8);
    set_instr(1, 4'h1, 4'h7, 4'h8, 4'h0, 16'd3);
    e0 = model_word(op_a[0], rd_a[0], rs1_a[0], rs2_a[0], imm_a[0], b);
    e1 = model_word(op_a[1], rd_a[1], rs1_a[1], rs2_a[1], imm_a[1], b);
    pulse_start(8'hFF, 2);
    feed(2, 3);
    n_total++; if (stall_cycles !== 3) $display("FAIL stall_cycles: got %0d want 3", stall_cycles); else n_pass++;
    n_total++; if (stall_bad !== 0) $display("FAIL stall_stable: got %0d unstable samples want 0", stall_bad); else n_pass++;
    n_total++; if (wa[0] !== 8'hFF || wa[1] !== 8'h00) $display("FAIL wrap_addr: got %h,%h want FF,00", wa[0], wa[1]); else n_pass++;
    n_total++; if (wd[0] !== e0 || wd[1] !== e1) $display("FAIL wrap_data: got %h,%h want %h,%h", wd[0], wd[1], e0, e1); else n_pass++;
  endtask
  task automatic test_len0_ignore;
    wa.delete(); wd.delete();
    pulse_start(8'h30, 0);
    @(negedge clk);
    n_total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL len0_done: done=%b busy=%b want 1 0", bus.done, bus.busy); else n_pass++;
    repeat (3) tick();
    n_total++; if (wa.size() !== 0) $display("FAIL len0_nowrite: got %0d writes want 0", wa.size()); else n_pass++;
    set_instr(0, 4'h4, 4'h1, 4'h1, 4'h0, 16'd1);
    set_instr(1, 4'hA, 4'h2, 4'h2, 4'h2, 16'd0);
    pulse_start(8'h50, 2);
    pulse_start(8'h90, 5);
    feed(2, 0);
    n_total++; if (wa.size() !== 2 || bus.done !== 1'b1) $display("FAIL start_ignored_count: got %0d writes done=%b want 2 1", wa.size(), bus.done); else n_pass++;
    n_total++; if (wa[0] !== 8'h50 || wa[1] !== 8'h51) $display("FAIL start_ignored_addr: got %h,%h want 50,51", wa[0], wa[1]); else n_pass++;
  endtask
  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int n, stall, nbad;
      logic [7:0] base;
      logic [15:0] exp_d [16];
      bit b;
      wa.delete(); wd.delete();
      n = $urandom_range(1, 6);
      stall = $urandom_range(0, 2);
      base = 8'($urandom);
      nbad = 0;
      for (int i = 0; i < n; i++) begin
        int t;
        t = int'($urandom_range(0, 300)) - 150;
        set_instr(i, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(t));
        exp_d[i] = model_word(op_a[i], rd_a[i], rs1_a[i], rs2_a[i], imm_a[i], b);
        nbad += int'(b);
      end
      pulse_start(base, n);
      feed(n, stall);
      n_total++; if (wa.size() !== n) $display("FAIL rand%0d_count: got %0d want %0d", r, wa.size(), n); else n_pass++;
      for (int i = 0; i < n; i++) begin
        n_total++;
        if (wd[i] !== exp_d[i] || wa[i] !== 8'(int'(base) + i))
          $display("FAIL rand%0d_w%0d: got %h@%h want %h@%h", r, i, wd[i], wa[i], exp_d[i], 8'(int'(base) + i));
        else n_pass++;
      end
      n_total++; if (bus.err !== (nbad > 0) || bus.err_cnt !== 8'(nbad)) $display("FAIL rand%0d_err: got %b/%0d want %b/%0d", r, bus.err, bus.err_cnt, nbad > 0, nbad); else n_pass++;
    end
  endtask
  task automatic test_async_reset;
    logic [15:0] e;
    bit b;
    pulse_start(8'h70, 1);
    bus.in_op = 4'h5; bus.in_rd = 4'h1; bus.in_rs1 = 4'h1; bus.in_rs2 = 4'h0; bus.in_imm = 16'd100;
    bus.in_valid = 1'b1;
    bus.mem_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (bus.mem_we !== 1'b1 || bus.err !== 1'b1) $display("FAIL arst_pre: mem_we=%b err=%b want 1 1", bus.mem_we, bus.err); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({bus.mem_we, bus.in_ready, bus.busy, bus.done, bus.err} !== 5'b0) $display("FAIL arst_ctrl: got %b want 00000", {bus.mem_we, bus.in_ready, bus.busy, bus.done, bus.err}); else n_pass++;
    n_total++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0000 || bus.err_cnt !== 8'd0) $display("FAIL arst_data: got %h/%h/%0d want 00/0000/0", bus.mem_addr, bus.mem_wdata, bus.err_cnt); else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    wa.delete(); wd.delete();
    set_instr(0, 4'hD, 4'h6, 4'h7, 4'h0, 16'hFFFD);
    e = model_word(op_a[0], rd_a[0], rs1_a[0], rs2_a[0], imm_a[0], b);
    pulse_start(8'h08, 1);
    feed(1, 0);
    n_total++; if (wa.size() !== 1 || wa[0] !== 8'h08 || wd[0] !== e) $display("FAIL arst_reload: got %0d writes %h@%h want 1 %h@08", wa.size(), wd[0], wa[0], e); else n_pass++;
  endtask
  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_jal();
    test_pair();
    test_illegal();
    test_stall_wrap();
    test_len0_ignore();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
